// File: rtl/e_card_power_seq.sv
// -----------------------------------------------------------------------------
// e_card_power_seq
//
// Host-side consumer of the card-detect interface. It qualifies the debounced
// slot status, sequences slot power through a ramp-up and a discharge interval,
// and latches insertion/removal events into sticky status bits that raise a
// maskable interrupt towards the SDIO host register block.
//
// Parameters
//   CNT_W        width of the interval counter
//   RAMP_CYCLES  clk cycles sd_pon is high before pwr_good asserts (1..2^CNT_W-1)
//   OFF_CYCLES   clk cycles sd_pon stays low after power-off before a new
//                power-up may start (1..2^CNT_W-1)
//
// Ports
//   clk            system clock (single domain)
//   rst            synchronous, active-high reset
//   card_inserted  debounced card presence from card detect
//   card_stable    presence / write-protect inputs are valid this cycle
//   wp_level       write-protect level from card detect
//   pwr_req        software power request (level)
//   int_en_ins     insertion interrupt enable
//   int_en_rem     removal interrupt enable
//   int_clr_ins    one-cycle pulse clearing int_ins_sts
//   int_clr_rem    one-cycle pulse clearing int_rem_sts
//   sd_pon         slot power enable
//   pwr_good       card power ramp complete
//   card_present   qualified presence
//   wp_status      qualified write protect
//   int_ins_sts    sticky insertion status
//   int_rem_sts    sticky removal status
//   irq            interrupt request
//   busy           sequencer is ramping up or discharging
// -----------------------------------------------------------------------------
module e_card_power_seq #(
  parameter int CNT_W       = 16,
  parameter int RAMP_CYCLES = 50000,
  parameter int OFF_CYCLES  = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic card_inserted,
  input  logic card_stable,
  input  logic wp_level,
  input  logic pwr_req,
  input  logic int_en_ins,
  input  logic int_en_rem,
  input  logic int_clr_ins,
  input  logic int_clr_rem,
  output logic sd_pon,
  output logic pwr_good,
  output logic card_present,
  output logic wp_status,
  output logic int_ins_sts,
  output logic int_rem_sts,
  output logic irq,
  output logic busy
);

  typedef enum logic [1:0] {
    S_OFF,
    S_RAMP_UP,
    S_ON,
    S_DISCHARGE
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an interval of N cycles is reached when cnt == N-1.
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic card_present_d;
  logic ins_evt;
  logic rem_evt;
  logic pwr_abort;

  // Presence and write protect are only trusted on cycles where card detect
  // flags them as stable; otherwise the last qualified values are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      card_present <= 1'b0;
      wp_status    <= 1'b0;
    end else if (card_stable) begin
      card_present <= card_inserted;
      wp_status    <= wp_level;
    end
  end

  // Edge detection on the qualified presence.
  assign ins_evt = card_present & ~card_present_d;
  assign rem_evt = ~card_present & card_present_d;

  // Sticky status bits. A new event on the same edge as a clear pulse wins,
  // so software never loses an event it has not yet seen. The bits latch
  // regardless of the interrupt enables so they can be polled.
  always_ff @(posedge clk) begin
    if (rst) begin
      card_present_d <= 1'b0;
      int_ins_sts    <= 1'b0;
      int_rem_sts    <= 1'b0;
    end else begin
      card_present_d <= card_present;
      int_ins_sts    <= ins_evt | (int_ins_sts & ~int_clr_ins);
      int_rem_sts    <= rem_evt | (int_rem_sts & ~int_clr_rem);
    end
  end

  assign irq = (int_ins_sts & int_en_ins) | (int_rem_sts & int_en_rem);

  // Power is withdrawn when software drops its request or the card leaves.
  assign pwr_abort = ~pwr_req | ~card_present;

  // State register and interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is reloaded to 0 on every state entry and
  // only counts inside the timed states, so it can never wrap. Discharge runs
  // to completion regardless of pwr_req or re-insertion, which guarantees the
  // minimum off time before the slot is powered again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (pwr_req && card_present) begin
          state_d = S_RAMP_UP;
          cnt_d   = '0;
        end
      end
      S_RAMP_UP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pwr_abort) begin
          state_d = S_DISCHARGE;
          cnt_d   = '0;
        end else if (cnt_q == RAMP_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (pwr_abort) begin
          state_d = S_DISCHARGE;
          cnt_d   = '0;
        end
      end
      S_DISCHARGE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == OFF_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Power outputs are decoded straight from the state register so they
  // change only on clock edges and cannot glitch.
  always_comb begin
    sd_pon   = 1'b0;
    pwr_good = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_OFF: begin
        sd_pon = 1'b0;
      end
      S_RAMP_UP: begin
        sd_pon = 1'b1;
        busy   = 1'b1;
      end
      S_ON: begin
        sd_pon   = 1'b1;
        pwr_good = 1'b1;
      end
      S_DISCHARGE: begin
        busy = 1'b1;
      end
      default: begin
        sd_pon = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_e_card_power_seq.sv
// -----------------------------------------------------------------------------
// tb_e_card_power_seq
//
// Bench for e_card_power_seq with short intervals (ramp 8, off 4). A driver
// walks through directed scenarios and then random traffic. For every cycle it
// drives, a cycle-based reference model predicts the output vector and pushes
// it into a scoreboard queue. An independent monitor pops one entry per clock
// and compares, and also measures the ramp and off intervals directly from
// sd_pon / pwr_good.
// -----------------------------------------------------------------------------
module tb_e_card_power_seq;

  localparam int CNT_W = 16;
  localparam int RAMP  = 8;
  localparam int OFFC  = 4;

  localparam int P_IDLE = 0;
  localparam int P_RAMP = 1;
  localparam int P_ON   = 2;
  localparam int P_DIS  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic ins;
    logic stable;
    logic wp;
    logic req;
    logic en_ins;
    logic en_rem;
    logic clr_ins;
    logic clr_rem;
  } stim_t;

  stim_t cur;

  logic sd_pon, pwr_good, card_present, wp_status;
  logic int_ins_sts, int_rem_sts, irq, busy;

  e_card_power_seq #(
    .CNT_W      (CNT_W),
    .RAMP_CYCLES(RAMP),
    .OFF_CYCLES (OFFC)
  ) dut (
    .clk          (clk),
    .rst          (cur.rst),
    .card_inserted(cur.ins),
    .card_stable  (cur.stable),
    .wp_level     (cur.wp),
    .pwr_req      (cur.req),
    .int_en_ins   (cur.en_ins),
    .int_en_rem   (cur.en_rem),
    .int_clr_ins  (cur.clr_ins),
    .int_clr_rem  (cur.clr_rem),
    .sd_pon       (sd_pon),
    .pwr_good     (pwr_good),
    .card_present (card_present),
    .wp_status    (wp_status),
    .int_ins_sts  (int_ins_sts),
    .int_rem_sts  (int_rem_sts),
    .irq          (irq),
    .busy         (busy)
  );

  // Scoreboard: expected output vector per clock edge.
  logic [7:0] sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: qualified inputs, previous presence, sticky bits,
  // and the power phase with the edge number at which it was entered.
  int   m_cyc   = 0;
  logic m_present, m_wp, m_pd, m_ins, m_rem;
  int   m_phase;
  int   m_start;

  // Predict the outputs after the next clock edge given the inputs held
  // across that edge.
  task automatic modelStep(input stim_t s, output logic [7:0] e);
    logic n_ins, n_rem, abort;
    m_cyc++;
    if (s.rst) begin
      m_present = 1'b0; m_wp = 1'b0; m_pd = 1'b0;
      m_ins = 1'b0; m_rem = 1'b0;
      m_phase = P_IDLE; m_start = m_cyc;
    end else begin
      abort = !s.req || !m_present;
      case (m_phase)
        P_IDLE: if (s.req && m_present) begin m_phase = P_RAMP; m_start = m_cyc; end
        P_RAMP: begin
          if (abort) begin m_phase = P_DIS; m_start = m_cyc; end
          else if (m_cyc - m_start == RAMP) begin m_phase = P_ON; m_start = m_cyc; end
        end
        P_ON:   if (abort) begin m_phase = P_DIS; m_start = m_cyc; end
        default: if (m_cyc - m_start == OFFC) begin m_phase = P_IDLE; m_start = m_cyc; end
      endcase
      n_ins = (m_present && !m_pd) || (m_ins && !s.clr_ins);
      n_rem = (!m_present && m_pd) || (m_rem && !s.clr_rem);
      m_pd = m_present;
      if (s.stable) begin m_present = s.ins; m_wp = s.wp; end
      m_ins = n_ins;
      m_rem = n_rem;
    end
    e = {(m_phase == P_RAMP) || (m_phase == P_ON),
         m_phase == P_ON,
         m_present, m_wp, m_ins, m_rem,
         (m_ins & s.en_ins) | (m_rem & s.en_rem),
         (m_phase == P_RAMP) || (m_phase == P_DIS)};
  endtask

  // Drive one input set for n cycles; each cycle queues its prediction.
  task automatic applyStimulus(input stim_t s, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur = s;
      modelStep(s, e);
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input logic [7:0] exp_v);
    logic [7:0] act;
    act = {sd_pon, pwr_good, card_present, wp_status, int_ins_sts, int_rem_sts, irq, busy};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL outputs t=%0t actual=%b expected=%b (sd_pon,pwr_good,present,wp,ins_sts,rem_sts,irq,busy)",
               $time, act, exp_v);
    end
  endtask

  // Monitor: one comparison per clock, plus direct interval measurements.
  int   hi_cnt   = 0;
  int   lo_cnt   = 0;
  logic powered  = 1'b0;
  logic prev_pg  = 1'b0;
  logic prev_pon = 1'b0;

  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
        if (cur.rst) begin
          hi_cnt = 0; lo_cnt = 0; powered = 1'b0;
        end else begin
          if (pwr_good === 1'b1 && !prev_pg) begin
            checks++;
            if (hi_cnt != RAMP) begin
              failures++;
              $display("[TB] FAIL ramp_len t=%0t actual=%0d required=%0d", $time, hi_cnt, RAMP);
            end
          end
          if (sd_pon === 1'b1 && !prev_pon && powered) begin
            checks++;
            if (lo_cnt < OFFC + 1) begin
              failures++;
              $display("[TB] FAIL off_len t=%0t actual=%0d required>=%0d", $time, lo_cnt, OFFC + 1);
            end
          end
          if (sd_pon === 1'b1 && pwr_good !== 1'b1) hi_cnt++; else hi_cnt = 0;
          if (sd_pon !== 1'b1) lo_cnt++; else lo_cnt = 0;
          if (sd_pon === 1'b1) powered = 1'b1;
        end
        prev_pg  = (pwr_good === 1'b1) && !cur.rst;
        prev_pon = (sd_pon === 1'b1) && !cur.rst;
      end
    end
  end

  initial begin
    stim_t s;
    cur = '0;
    cur.rst = 1'b1;
    s = cur;

    // Reset, then insertion with the insertion interrupt enabled.
    applyStimulus(s, 2);
    s.rst = 1'b0; s.en_ins = 1'b1;
    applyStimulus(s, 1);
    s.ins = 1'b1; s.stable = 1'b1;
    applyStimulus(s, 3);

    // Power up to ON.
    s.req = 1'b1;
    applyStimulus(s, 12);

    // Removal while ON, full discharge.
    s.en_rem = 1'b1; s.ins = 1'b0;
    applyStimulus(s, 8);

    // Re-insert, start ramp, abort at ramp cycle 3, re-request during discharge.
    s.ins = 1'b1;
    applyStimulus(s, 5);
    s.req = 1'b0;
    applyStimulus(s, 1);
    s.req = 1'b1;
    applyStimulus(s, 16);

    // Stability gating: toggles ignored while card_stable is low.
    s.stable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s.ins = ~s.ins; s.wp = ~s.wp;
      applyStimulus(s, 1);
    end
    s.stable = 1'b1; s.ins = 1'b1; s.wp = 1'b1;
    applyStimulus(s, 2);

    // Clear collision with a new insertion event, then a lone clear.
    s.req = 1'b0; s.ins = 1'b0;
    applyStimulus(s, 8);
    s.ins = 1'b1;
    applyStimulus(s, 1);
    s.clr_ins = 1'b1;
    applyStimulus(s, 1);
    s.clr_ins = 1'b0;
    applyStimulus(s, 2);
    s.clr_ins = 1'b1; s.clr_rem = 1'b1;
    applyStimulus(s, 1);
    s.clr_ins = 1'b0; s.clr_rem = 1'b0;
    applyStimulus(s, 2);

    // Random traffic with sticky levels so full ramps and discharges occur.
    s.req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      s.rst     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 23) == 0) s.ins = ~s.ins;
      s.stable  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) s.wp = ~s.wp;
      if ($urandom_range(0, 17) == 0) s.req = ~s.req;
      if ($urandom_range(0, 19) == 0) s.en_ins = ~s.en_ins;
      if ($urandom_range(0, 19) == 0) s.en_rem = ~s.en_rem;
      s.clr_ins = ($urandom_range(0, 9) == 0);
      s.clr_rem = ($urandom_range(0, 9) == 0);
      applyStimulus(s, 1);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
